rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges core writebacks and a 4-deep coprocessor result FIFO onto one regfile write port.
// Optional feature: define RF_WB_PENDING_CHECK_EN to build the rs1/rs2 pending-write hazard query.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_valid,
    input  logic [4:0]  core_rd_addr,
    input  logic [31:0] core_rd_data,
    output logic        core_stall,
    input  logic        cop_valid,
    output logic        cop_ready,
    input  logic [4:0]  cop_rd_addr,
    input  logic [31:0] cop_rd_data,
    output logic        w_enable,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_pending,
    output logic        rs2_pending
);
    // Extra headroom keeps the counter at least one bit wide for tiny limits.
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [SW-1:0] LIMIT_S = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_addr_r [4];
    logic [31:0]   fifo_data_r [4];
    logic [1:0]    wr_ptr_r;
    logic [1:0]    rd_ptr_r;
    logic [2:0]    count_r;
    logic [2:0]    count_next_s;
    logic [SW-1:0] starve_r;
    logic [SW-1:0] starve_next_s;
    logic          w_enable_r;
    logic [4:0]    rd_addr_r;
    logic [31:0]   rd_data_r;

    logic          fifo_empty_s;
    logic          ready_s;
    logic          stall_s;
    logic          core_grant_s;
    logic          fifo_grant_s;
    logic          push_s;
    logic          write_s;
    logic [4:0]    sel_addr_s;
    logic [31:0]   sel_data_s;

    // Arbitration, FIFO occupancy and starvation bookkeeping.
    always_comb begin
        fifo_empty_s = (count_r == 3'd0);
        ready_s      = !rst && (count_r != 3'd4);
        stall_s      = !rst && !fifo_empty_s && (starve_r == LIMIT_S);
        core_grant_s = core_valid && !stall_s;
        fifo_grant_s = !core_grant_s && !fifo_empty_s;
        push_s       = cop_valid && ready_s;

        if (core_grant_s) begin
            sel_addr_s = core_rd_addr;
            sel_data_s = core_rd_data;
        end else begin
            sel_addr_s = fifo_addr_r[rd_ptr_r];
            sel_data_s = fifo_data_r[rd_ptr_r];
        end
        // Writes to x0 are dropped but still consume their grant.
        write_s = (core_grant_s || fifo_grant_s) && (sel_addr_s != 5'd0);

        case ({push_s, fifo_grant_s})
            2'b10:   count_next_s = count_r + 3'd1;
            2'b01:   count_next_s = count_r - 3'd1;
            default: count_next_s = count_r;
        endcase

        if (fifo_grant_s || fifo_empty_s) begin
            starve_next_s = {SW{1'b0}};
        end else if (starve_r != LIMIT_S) begin
            starve_next_s = starve_r + SW'(1);
        end else begin
            starve_next_s = starve_r;
        end
    end

    // FIFO storage; only occupied slots are ever read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= cop_rd_addr;
            fifo_data_r[wr_ptr_r] <= cop_rd_data;
        end
    end

    // FIFO pointers, occupancy and starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            starve_r <= {SW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (fifo_grant_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            count_r  <= count_next_s;
            starve_r <= starve_next_s;
        end
    end

    // Registered regfile write port; address/data hold when no write issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_enable_r <= 1'b0;
            rd_addr_r  <= 5'd0;
            rd_data_r  <= 32'd0;
        end else begin
            w_enable_r <= write_s;
            if (write_s) begin
                rd_addr_r <= sel_addr_s;
                rd_data_r <= sel_data_s;
            end
        end
    end

    assign cop_ready  = ready_s;
    assign core_stall = stall_s;
    assign w_enable   = w_enable_r;
    assign rd_addr    = rd_addr_r;
    assign rd_data    = rd_data_r;

`ifdef RF_WB_PENDING_CHECK_EN
    function automatic logic entry_live(input logic [1:0] idx, input logic [1:0] head,
                                        input logic [2:0] cnt);
        logic [1:0] off;
        off = idx - head;
        return ({1'b0, off} < cnt);
    endfunction

    logic rs1_hit_s;
    logic rs2_hit_s;

    // Match source registers against buffered entries and the write in flight.
    always_comb begin
        rs1_hit_s = w_enable_r && (rd_addr_r == rs1_addr);
        rs2_hit_s = w_enable_r && (rd_addr_r == rs2_addr);
        for (int i = 0; i < 4; i++) begin
            rs1_hit_s = rs1_hit_s | (entry_live(2'(i), rd_ptr_r, count_r) && (fifo_addr_r[i] == rs1_addr));
            rs2_hit_s = rs2_hit_s | (entry_live(2'(i), rd_ptr_r, count_r) && (fifo_addr_r[i] == rs2_addr));
        end
    end

    assign rs1_pending = !rst && (rs1_addr != 5'd0) && rs1_hit_s;
    assign rs2_pending = !rst && (rs2_addr != 5'd0) && rs2_hit_s;
`else
    logic unused_rs_s;
    assign unused_rs_s = ^{rs1_addr, rs2_addr};
    assign rs1_pending = 1'b0;
    assign rs2_pending = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based model of the arbitration rules.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    localparam int LIMIT = 7;
`ifdef RF_WB_PENDING_CHECK_EN
    localparam bit PEND_ON = 1'b1;
`else
    localparam bit PEND_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid;
    logic [4:0]  core_rd_addr;
    logic [31:0] core_rd_data;
    logic        core_stall;
    logic        cop_valid;
    logic        cop_ready;
    logic [4:0]  cop_rd_addr;
    logic [31:0] cop_rd_data;
    logic        w_enable;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_pending;
    logic        rs2_pending;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: pending results in arrival order plus the visible write port.
    logic [36:0] mq[$];
    int          m_wait;
    logic        m_wen;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        exp_ready, exp_stall, exp_p1, exp_p2;

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .core_valid(core_valid), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
        .core_stall(core_stall),
        .cop_valid(cop_valid), .cop_ready(cop_ready), .cop_rd_addr(cop_rd_addr), .cop_rd_data(cop_rd_data),
        .w_enable(w_enable), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending)
    );

    always #5 clk = ~clk;

    function automatic logic pend(input logic [4:0] rs);
        logic hit;
        hit = m_wen && (m_addr == rs);
        foreach (mq[i]) if (mq[i][36:32] == rs) hit = 1'b1;
        return PEND_ON && !rst && (rs != 5'd0) && hit;
    endfunction

    // Wait for the mid-cycle sample point and compute expected combinational outputs.
    task automatic settle();
        @(negedge clk);
        exp_ready = !rst && (mq.size() < 4);
        exp_stall = !rst && (mq.size() != 0) && (m_wait == LIMIT);
        exp_p1    = pend(rs1_addr);
        exp_p2    = pend(rs2_addr);
    endtask

    // Advance the model by one clock edge, then let the DUT take the same edge.
    task automatic tick();
        logic [36:0] src;
        logic gc, gf, pu;
        int   was;
        if (rst) begin
            mq.delete();
            m_wait = 0; m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        end else begin
            gc  = core_valid && !exp_stall;
            gf  = !gc && (mq.size() != 0);
            pu  = cop_valid && exp_ready;
            was = mq.size();
            if (gc) src = {core_rd_addr, core_rd_data};
            else if (gf) src = mq.pop_front();
            else src = '0;
            m_wait = (gf || was == 0) ? 0 : m_wait + 1;
            if (pu) mq.push_back({cop_rd_addr, cop_rd_data});
            m_wen = (gc || gf) && (src[36:32] != 5'd0);
            if (m_wen) begin
                m_addr = src[36:32];
                m_data = src[31:0];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        core_valid = 1'b0; core_rd_addr = 5'd0; core_rd_data = 32'd0;
        cop_valid = 1'b0; cop_rd_addr = 5'd0; cop_rd_data = 32'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        rst = 1'b1; cop_valid = 1'b1; core_valid = 1'b1;
        settle();
        n_cmp++; if (cop_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b expected 0", cop_ready); end
        n_cmp++; if (core_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", core_stall); end
        n_cmp++; if (rs1_pending !== 1'b0) begin n_bad++; $display("FAIL rst_pend: got %b expected 0", rs1_pending); end
        tick();
        n_cmp++; if (w_enable !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %b expected 0", w_enable); end
        n_cmp++; if (rd_addr !== 5'd0) begin n_bad++; $display("FAIL rst_addr: got %0d expected 0", rd_addr); end
        n_cmp++; if (rd_data !== 32'd0) begin n_bad++; $display("FAIL rst_data: got %h expected 0", rd_data); end
        rst = 1'b0; idle_inputs(); rs1_addr = 5'd3;
        settle();
        n_cmp++; if (cop_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready: got %b expected 1", cop_ready); end
        n_cmp++; if (rs1_pending !== 1'b0) begin n_bad++; $display("FAIL post_rst_pend: got %b expected 0", rs1_pending); end
        tick();
    endtask

    task automatic test_core_write();
        apply_reset();
        core_valid = 1'b1; core_rd_addr = 5'd3; core_rd_data = 32'hDEADBEEF;
        settle();
        n_cmp++; if (core_stall !== 1'b0) begin n_bad++; $display("FAIL core_stall: got %b expected 0", core_stall); end
        tick();
        n_cmp++; if (w_enable !== 1'b1) begin n_bad++; $display("FAIL core_wen: got %b expected 1", w_enable); end
        n_cmp++; if (rd_addr !== 5'd3) begin n_bad++; $display("FAIL core_addr: got %0d expected 3", rd_addr); end
        n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL core_data: got %h expected deadbeef", rd_data); end
        idle_inputs();
    endtask

    task automatic test_starvation();
        int acc;
        apply_reset();
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            core_valid = 1'b1; core_rd_addr = 5'd1; core_rd_data = $urandom;
            cop_valid = 1'b1; cop_rd_addr = 5'(10 + acc); cop_rd_data = 32'hC000_0000 | 32'(acc);
            settle();
            n_cmp++; if (cop_ready !== (i < 4)) begin n_bad++; $display("FAIL starve_ready cyc %0d: got %b expected %b", i, cop_ready, (i < 4)); end
            n_cmp++; if (core_stall !== (i == 8)) begin n_bad++; $display("FAIL starve_stall cyc %0d: got %b expected %b", i, core_stall, (i == 8)); end
            if (i < 4) acc++;
            tick();
            n_cmp++; if (w_enable !== 1'b1 || rd_addr !== ((i == 8) ? 5'd10 : 5'd1)) begin
                n_bad++; $display("FAIL starve_write cyc %0d: got wen=%b addr=%0d expected wen=1 addr=%0d", i, w_enable, rd_addr, (i == 8) ? 10 : 1);
            end
        end
        core_valid = 1'b0;
        for (int j = 0; j < 20 && (acc < 5 || mq.size() != 0); j++) begin
            cop_valid = (acc < 5); cop_rd_addr = 5'(10 + acc); cop_rd_data = 32'hC000_0000 | 32'(acc);
            settle();
            n_cmp++; if (cop_ready !== exp_ready) begin n_bad++; $display("FAIL drain_ready: got %b expected %b", cop_ready, exp_ready); end
            if (cop_valid && exp_ready) acc++;
            tick();
            n_cmp++; if (w_enable !== m_wen || rd_addr !== m_addr || rd_data !== m_data) begin
                n_bad++; $display("FAIL drain_write: got %b/%0d/%h expected %b/%0d/%h", w_enable, rd_addr, rd_data, m_wen, m_addr, m_data);
            end
        end
        n_cmp++; if (acc != 5 || mq.size() != 0) begin n_bad++; $display("FAIL drain_timeout: got %0d accepted expected 5", acc); end
        idle_inputs();
    endtask

    task automatic test_same_cycle();
        apply_reset();
        core_valid = 1'b1; core_rd_addr = 5'd5; core_rd_data = 32'h0000_0055;
        cop_valid = 1'b1; cop_rd_addr = 5'd10; cop_rd_data = 32'h12345678;
        settle();
        n_cmp++; if (cop_ready !== 1'b1) begin n_bad++; $display("FAIL same_ready: got %b expected 1", cop_ready); end
        tick();
        n_cmp++; if (w_enable !== 1'b1 || rd_addr !== 5'd5) begin n_bad++; $display("FAIL same_core: got %b/%0d expected 1/5", w_enable, rd_addr); end
        idle_inputs();
        settle(); tick();
        n_cmp++; if (w_enable !== 1'b1 || rd_addr !== 5'd10 || rd_data !== 32'h12345678) begin
            n_bad++; $display("FAIL same_cop: got %b/%0d/%h expected 1/10/12345678", w_enable, rd_addr, rd_data);
        end
    endtask

    task automatic test_addr_zero();
        apply_reset();
        core_valid = 1'b1; core_rd_addr = 5'd7; core_rd_data = 32'h0000_0077;
        cop_valid = 1'b1; cop_rd_addr = 5'd0; cop_rd_data = 32'h0000_AAAA;
        settle(); tick();
        idle_inputs();
        settle(); tick();
        n_cmp++; if (w_enable !== 1'b0) begin n_bad++; $display("FAIL zero_wen: got %b expected 0", w_enable); end
        n_cmp++; if (rd_addr !== 5'd7 || rd_data !== 32'h77) begin n_bad++; $display("FAIL zero_hold: got %0d/%h expected 7/77", rd_addr, rd_data); end
        n_cmp++; if (dut.count_r !== 3'd0) begin n_bad++; $display("FAIL zero_count: got %0d expected 0", dut.count_r); end
        settle();
        n_cmp++; if (cop_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %b expected 1", cop_ready); end
        tick();
    endtask

    task automatic test_pending();
        logic [3:0] want;
        apply_reset();
        want = {1'b0, PEND_ON, PEND_ON, PEND_ON};
        rs1_addr = 5'd10; rs2_addr = 5'd0;
        core_valid = 1'b1; core_rd_addr = 5'd1; cop_valid = 1'b1; cop_rd_addr = 5'd10; cop_rd_data = 32'hABCD0010;
        settle(); tick();
        cop_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            core_valid = (k == 0);
            settle();
            n_cmp++; if (rs1_pending !== want[k]) begin n_bad++; $display("FAIL pend_rs1 step %0d: got %b expected %b", k, rs1_pending, want[k]); end
            n_cmp++; if (rs2_pending !== 1'b0) begin n_bad++; $display("FAIL pend_rs2 step %0d: got %b expected 0", k, rs2_pending); end
            if (k == 2) begin
                n_cmp++; if (w_enable !== 1'b1 || rd_addr !== 5'd10) begin n_bad++; $display("FAIL pend_write: got %b/%0d expected 1/10", w_enable, rd_addr); end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            core_valid = 1'b1; core_rd_addr = 5'd2;
            cop_valid = 1'b1; cop_rd_addr = 5'(20 + k); cop_rd_data = 32'(k);
            settle(); tick();
        end
        n_cmp++; if (dut.count_r !== 3'd3) begin n_bad++; $display("FAIL mid_fill: got %0d expected 3", dut.count_r); end
        rst = 1'b1; rs1_addr = 5'd20;
        settle();
        n_cmp++; if (cop_ready !== 1'b0 || core_stall !== 1'b0) begin n_bad++; $display("FAIL mid_rst_outs: got %b/%b expected 0/0", cop_ready, core_stall); end
        n_cmp++; if (rs1_pending !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pend: got %b expected 0", rs1_pending); end
        tick();
        n_cmp++; if (dut.count_r !== 3'd0 || w_enable !== 1'b0) begin n_bad++; $display("FAIL mid_rst_clear: got %0d/%b expected 0/0", dut.count_r, w_enable); end
        rst = 1'b0; idle_inputs(); rs1_addr = 5'd20;
        settle();
        n_cmp++; if (cop_ready !== 1'b1 || rs1_pending !== 1'b0) begin n_bad++; $display("FAIL mid_after: got %b/%b expected 1/0", cop_ready, rs1_pending); end
        tick();
        n_cmp++; if (w_enable !== 1'b0) begin n_bad++; $display("FAIL mid_discard: got %b expected 0", w_enable); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            core_valid   = ($urandom_range(0, 9) < 7);
            core_rd_addr = 5'($urandom_range(0, 15));
            core_rd_data = $urandom;
            cop_valid    = ($urandom_range(0, 9) < 5);
            cop_rd_addr  = 5'($urandom_range(0, 15));
            cop_rd_data  = $urandom;
            rs1_addr     = 5'($urandom_range(0, 15));
            rs2_addr     = 5'($urandom_range(0, 15));
            settle();
            n_cmp++; if (cop_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready cyc %0d: got %b expected %b", c, cop_ready, exp_ready); end
            n_cmp++; if (core_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall cyc %0d: got %b expected %b", c, core_stall, exp_stall); end
            n_cmp++; if (rs1_pending !== exp_p1 || rs2_pending !== exp_p2) begin
                n_bad++; $display("FAIL rnd_pend cyc %0d: got %b%b expected %b%b", c, rs1_pending, rs2_pending, exp_p1, exp_p2);
            end
            tick();
            n_cmp++; if (w_enable !== m_wen || rd_addr !== m_addr || rd_data !== m_data) begin
                n_bad++; $display("FAIL rnd_write cyc %0d: got %b/%0d/%h expected %b/%0d/%h", c, w_enable, rd_addr, rd_data, m_wen, m_addr, m_data);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        m_wait = 0; m_wen = 1'b0; m_addr = 5'd0; m_data = 32'd0;
        exp_ready = 1'b0; exp_stall = 1'b0; exp_p1 = 1'b0; exp_p2 = 1'b0;
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_core_write();
        test_starvation();
        test_same_cycle();
        test_addr_zero();
        test_pending();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
